// File: rtl/uart_pkg.sv
// Shared types for the UART PHY: parity modes and TX/RX FSM state encodings.
package uart_pkg;

    localparam int PARITY_W = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // Encoding 3 is reserved and behaves as "no parity".
    function automatic parity_e decode_parity(input logic [PARITY_W-1:0] cfg);
        parity_e p;
        p = PAR_NONE;
        if (cfg == 2'd1)      p = PAR_EVEN;
        else if (cfg == 2'd2) p = PAR_ODD;
        return p;
    endfunction

endpackage

// File: rtl/uart_phy_rx.sv
// UART receiver: rxd synchroniser, oversample tick counter and RX FSM.
// Break detection is built only when UART_PHY_BREAK_DET_EN is defined.
module uart_phy_rx
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVS         = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    i_cfg_div,
    input  logic [PARITY_W-1:0] i_cfg_parity,
    input  logic                i_loopback,
    input  logic                i_lb_line,
    input  logic                i_rxd,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_perr,
    output logic                o_ferr,
    output logic                o_break
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e              r_state;
    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_div_cfg;
    logic [TW-1:0]          r_tick;
    logic [BW-1:0]          r_bit;
    parity_e                r_par;
    logic [DATA_W-1:0]      r_sh;
    logic                   r_acc;
    logic                   r_perr_pend;
    logic                   w_line;
    logic                   w_tick;
    logic                   w_mid;
    logic                   w_break;

    // Loopback taps the internal TX line directly; it is already synchronous.
    assign w_line = i_loopback ? i_lb_line : r_sync[SYNC_STAGES-1];
    assign w_tick = (r_div == r_div_cfg);
    assign w_mid  = w_tick && (r_tick == TW'(OVS - 1));

    // Two-or-more flop synchroniser for the asynchronous pad, idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
    end

`ifdef UART_PHY_BREAK_DET_EN
    logic r_pbit;
    logic r_break;

    assign w_break = (r_state == RX_STOP) && w_mid && !w_line && (r_sh == '0) && !r_pbit;
    assign o_break = r_break;

    // Remember the received parity bit (0 when parity is off) and pulse on break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pbit  <= 1'b0;
            r_break <= 1'b0;
        end else begin
            r_break <= w_break;
            if (r_state == RX_IDLE)                  r_pbit <= 1'b0;
            else if (r_state == RX_PARITY && w_mid)  r_pbit <= w_line;
        end
    end
`else
    assign w_break = 1'b0;
    assign o_break = 1'b0;
`endif

    // RX FSM with prescaler/tick counters; restarts the timebase on the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RX_IDLE;
            r_div       <= '0;
            r_div_cfg   <= '0;
            r_tick      <= '0;
            r_bit       <= '0;
            r_par       <= PAR_NONE;
            r_sh        <= '0;
            r_acc       <= 1'b0;
            r_perr_pend <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_perr      <= 1'b0;
            o_ferr      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_tick <= r_tick + 1'b1;
            case (r_state)
                RX_IDLE: if (!w_line) begin
                    r_div       <= '0;
                    r_tick      <= '0;
                    r_div_cfg   <= i_cfg_div;
                    r_par       <= decode_parity(i_cfg_parity);
                    r_perr_pend <= 1'b0;
                    r_state     <= RX_START;
                end
                RX_START: if (w_tick && r_tick == TW'(OVS/2 - 1)) begin
                    r_tick <= '0;
                    r_bit  <= '0;
                    r_acc  <= 1'b0;
                    // A line that is high again at mid-start was a glitch.
                    r_state <= w_line ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (w_mid) begin
                    r_tick <= '0;
                    r_sh   <= {w_line, r_sh[DATA_W-1:1]};
                    r_acc  <= r_acc ^ w_line;
                    r_bit  <= r_bit + 1'b1;
                    if (r_bit == BW'(DATA_W - 1))
                        r_state <= (r_par == PAR_NONE) ? RX_STOP : RX_PARITY;
                end
                RX_PARITY: if (w_mid) begin
                    r_tick      <= '0;
                    r_perr_pend <= (r_par == PAR_ODD) ? ~(r_acc ^ w_line) : (r_acc ^ w_line);
                    r_state     <= RX_STOP;
                end
                RX_STOP: if (w_mid) begin
                    r_tick <= '0;
                    if (w_break) begin
                        r_state <= RX_WAIT_HIGH;
                    end else begin
                        o_valid <= 1'b1;
                        o_data  <= r_sh;
                        o_perr  <= r_perr_pend;
                        o_ferr  <= ~w_line;
                        r_state <= w_line ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: if (w_line) r_state <= RX_IDLE;
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_phy.sv
// UART PHY top: TX FSM with its own baud timebase, loopback mux and the RX sub-block.
// Optional break detection in RX is enabled by defining UART_PHY_BREAK_DET_EN.
module uart_phy
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVS         = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [PARITY_W-1:0] cfg_parity,
    input  logic                cfg_stop2,
    input  logic                cfg_loopback,
    input  logic                tx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                rx_valid,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_perr,
    output logic                rx_ferr,
    output logic                rx_break,
    output logic                uart_txd,
    input  logic                uart_rxd
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);

    tx_state_e         r_tx_state;
    logic [DIV_W-1:0]  r_tx_div;
    logic [DIV_W-1:0]  r_tx_div_cfg;
    logic [TW-1:0]     r_tx_tick;
    logic [BW-1:0]     r_tx_bit;
    logic [DATA_W-1:0] r_tx_sh;
    logic              r_tx_pbit;
    logic              r_tx_par_en;
    logic              r_tx_stop2;
    logic              r_txd;
    logic              r_tx_ready;
    logic              r_tx_busy;
    parity_e           w_tx_par;
    logic              w_tx_div_end;
    logic              w_tx_bit_end;

    assign w_tx_par     = decode_parity(cfg_parity);
    assign w_tx_div_end = (r_tx_div == r_tx_div_cfg);
    assign w_tx_bit_end = w_tx_div_end && (r_tx_tick == TW'(OVS - 1));

    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;
    // In loopback the pad idles high so the far end sees no traffic.
    assign uart_txd = cfg_loopback ? 1'b1 : r_txd;

    // TX FSM; the bit timebase is cleared on accept so the start bit is exactly one bit long.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_div     <= '0;
            r_tx_div_cfg <= '0;
            r_tx_tick    <= '0;
            r_tx_bit     <= '0;
            r_tx_sh      <= '0;
            r_tx_pbit    <= 1'b0;
            r_tx_par_en  <= 1'b0;
            r_tx_stop2   <= 1'b0;
            r_txd        <= 1'b1;
            r_tx_ready   <= 1'b1;
            r_tx_busy    <= 1'b0;
        end else begin
            if (r_tx_state != TX_IDLE) begin
                if (w_tx_div_end) begin
                    r_tx_div  <= '0;
                    r_tx_tick <= (r_tx_tick == TW'(OVS - 1)) ? '0 : r_tx_tick + 1'b1;
                end else begin
                    r_tx_div  <= r_tx_div + 1'b1;
                end
            end
            case (r_tx_state)
                TX_IDLE: if (tx_valid && r_tx_ready) begin
                    r_tx_div     <= '0;
                    r_tx_tick    <= '0;
                    r_tx_div_cfg <= cfg_div;
                    r_tx_sh      <= tx_data;
                    r_tx_pbit    <= (^tx_data) ^ (w_tx_par == PAR_ODD);
                    r_tx_par_en  <= (w_tx_par != PAR_NONE);
                    r_tx_stop2   <= cfg_stop2;
                    r_txd        <= 1'b0;
                    r_tx_ready   <= 1'b0;
                    r_tx_busy    <= 1'b1;
                    r_tx_state   <= TX_START;
                end
                TX_START: if (w_tx_bit_end) begin
                    r_txd      <= r_tx_sh[0];
                    r_tx_sh    <= r_tx_sh >> 1;
                    r_tx_bit   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: if (w_tx_bit_end) begin
                    if (r_tx_bit == BW'(DATA_W - 1)) begin
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_par_en ? r_tx_pbit : 1'b1;
                        r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        r_txd    <= r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end
                end
                TX_PARITY: if (w_tx_bit_end) begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: if (w_tx_bit_end) begin
                    // r_tx_bit counts stop bits already sent.
                    if (r_tx_stop2 && r_tx_bit == '0) begin
                        r_tx_bit <= 1'b1;
                    end else begin
                        r_tx_ready <= 1'b1;
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_phy_rx #(
        .DATA_W      (DATA_W),
        .OVS         (OVS),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_div    (cfg_div),
        .i_cfg_parity (cfg_parity),
        .i_loopback   (cfg_loopback),
        .i_lb_line    (r_txd),
        .i_rxd        (uart_rxd),
        .o_valid      (rx_valid),
        .o_data       (rx_data),
        .o_perr       (rx_perr),
        .o_ferr       (rx_ferr),
        .o_break      (rx_break)
    );

endmodule
